// File: rtl/snitch_icache_lookup_sched.sv
// snitch_icache_lookup_sched
// Shares the single icache lookup request port between NR_PORTS fetch
// requesters with round-robin arbitration and grant locking, tags each lookup
// with the requester index, and sequences flushes (stop issuing, drain
// in-flight lookups, then run the lookup flush handshake).
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   req_addr_i/req_id_i    per-requester fetch address and transaction ID
//   req_valid_i/ready_o    per-requester handshake
//   lookup_addr_o/id_o     issued lookup; id = {grant index, requester ID}
//   lookup_valid_o/ready_i lookup stage handshake
//   lookup_done_i          one lookup result consumed by the lookup stage
//   lookup_flush_valid_o   flush request to the lookup stage
//   lookup_flush_ready_i   lookup stage flush complete
//   flush_i                flush request pulse
//   flush_busy_o           flush pending or in progress
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | normal operation, lookups issued while below MAX_OUTST
// DRAIN | no new grants, waiting for outstanding lookups to complete
// FLUSH | lookup_flush_valid_o high until lookup_flush_ready_i
module snitch_icache_lookup_sched #(
  parameter int NR_PORTS  = 2,
  parameter int FETCH_AW  = 32,
  parameter int ID_WIDTH  = 3,
  parameter int MAX_OUTST = 2
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic [NR_PORTS-1:0][FETCH_AW-1:0]         req_addr_i,
  input  logic [NR_PORTS-1:0][ID_WIDTH-1:0]         req_id_i,
  input  logic [NR_PORTS-1:0]                       req_valid_i,
  output logic [NR_PORTS-1:0]                       req_ready_o,
  output logic [FETCH_AW-1:0]                       lookup_addr_o,
  output logic [ID_WIDTH+$clog2(NR_PORTS)-1:0]      lookup_id_o,
  output logic                                      lookup_valid_o,
  input  logic                                      lookup_ready_i,
  input  logic                                      lookup_done_i,
  output logic                                      lookup_flush_valid_o,
  input  logic                                      lookup_flush_ready_i,
  input  logic                                      flush_i,
  output logic                                      flush_busy_o
);

  localparam int IDX_W = $clog2(NR_PORTS);
  localparam int OW    = $clog2(MAX_OUTST + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, DRAIN = 2'd1, FLUSH = 2'd2} state_e;

  state_e           state_q;
  logic [IDX_W-1:0] rr_q, lock_idx_q, arb_idx, grant, cidx;
  logic             lock_q, flush_pend_q;
  logic [OW-1:0]    outst_q;
  logic             issue_allowed, handshake, enter_flush, found;
  int               cand;

  // First valid requester at or above rr_q, wrapping by compare so that
  // non-power-of-two port counts work.
  always_comb begin
    arb_idx = '0;
    found   = 1'b0;
    cand    = 0;
    cidx    = '0;
    for (int i = 0; i < NR_PORTS; i++) begin
      cand = int'(rr_q) + i;
      if (cand >= NR_PORTS) cand = cand - NR_PORTS;
      cidx = IDX_W'(cand);
      if (!found && req_valid_i[cidx]) begin
        found   = 1'b1;
        arb_idx = cidx;
      end
    end
  end

  assign grant = lock_q ? lock_idx_q : arb_idx;

  // A locked request was already presented, so it must be allowed to finish
  // even if a flush is pending or the state has moved on.
  assign issue_allowed = lock_q |
                         ((state_q == IDLE) && !flush_pend_q && (outst_q < OW'(MAX_OUTST)));

  assign lookup_valid_o = issue_allowed & (lock_q | (|req_valid_i));
  assign lookup_addr_o  = req_addr_i[grant];
  assign lookup_id_o    = {grant, req_id_i[grant]};
  assign handshake      = lookup_valid_o & lookup_ready_i;

  always_comb begin
    req_ready_o = '0;
    for (int g = 0; g < NR_PORTS; g++) begin
      req_ready_o[g] = issue_allowed & lookup_ready_i & (grant == IDX_W'(g));
    end
  end

  assign enter_flush          = (state_q == DRAIN) && (outst_q == '0) && !handshake;
  assign lookup_flush_valid_o = (state_q == FLUSH);
  assign flush_busy_o         = flush_pend_q | (state_q != IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      rr_q         <= '0;
      lock_q       <= 1'b0;
      lock_idx_q   <= '0;
      outst_q      <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      if (handshake) begin
        lock_q <= 1'b0;
        rr_q   <= (grant == IDX_W'(NR_PORTS - 1)) ? '0 : grant + IDX_W'(1);
      end else if (lookup_valid_o) begin
        lock_q     <= 1'b1;
        lock_idx_q <= grant;
      end

      case ({handshake, lookup_done_i})
        2'b10:   outst_q <= outst_q + OW'(1);
        2'b01:   if (outst_q != '0) outst_q <= outst_q - OW'(1);
        default: ;
      endcase

      // A pulse arriving on the cycle we enter FLUSH queues another flush.
      flush_pend_q <= (flush_pend_q & ~enter_flush) | flush_i;

      case (state_q)
        IDLE:    if (flush_pend_q && !lock_q) state_q <= DRAIN;
        DRAIN:   if (enter_flush) state_q <= FLUSH;
        FLUSH:   if (lookup_flush_ready_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(lookup_done_i && outst_q == '0))
        else $error("lookup_done_i with no lookup outstanding");
      assert (!(lock_q && !req_valid_i[lock_idx_q]))
        else $error("requester dropped valid while locked");
    end
  end

endmodule

// File: tb/tb_snitch_icache_lookup_sched.sv
module tb_snitch_icache_lookup_sched;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [1:0][31:0]  req_addr_i;
  logic [1:0][2:0]   req_id_i;
  logic [1:0]        req_valid_i;
  logic [1:0]        req_ready_o;
  logic [31:0]       lookup_addr_o;
  logic [3:0]        lookup_id_o;
  logic              lookup_valid_o;
  logic              lookup_ready_i;
  logic              lookup_done_i;
  logic              lookup_flush_valid_o;
  logic              lookup_flush_ready_i;
  logic              flush_i;
  logic              flush_busy_o;

  int compared = 0;
  int mismatched = 0;

  snitch_icache_lookup_sched dut (
    .clk_i                (clk_i),
    .rst_ni               (rst_ni),
    .req_addr_i           (req_addr_i),
    .req_id_i             (req_id_i),
    .req_valid_i          (req_valid_i),
    .req_ready_o          (req_ready_o),
    .lookup_addr_o        (lookup_addr_o),
    .lookup_id_o          (lookup_id_o),
    .lookup_valid_o       (lookup_valid_o),
    .lookup_ready_i       (lookup_ready_i),
    .lookup_done_i        (lookup_done_i),
    .lookup_flush_valid_o (lookup_flush_valid_o),
    .lookup_flush_ready_i (lookup_flush_ready_i),
    .flush_i              (flush_i),
    .flush_busy_o         (flush_busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp)
      else begin
        mismatched++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  initial begin
    rst_ni               = 1'b0;
    req_addr_i[0]        = 32'h0;
    req_addr_i[1]        = 32'h0;
    req_id_i[0]          = 3'h0;
    req_id_i[1]          = 3'h0;
    req_valid_i          = 2'b00;
    lookup_ready_i       = 1'b0;
    lookup_done_i        = 1'b0;
    lookup_flush_ready_i = 1'b0;
    flush_i              = 1'b0;

    // reset state
    #3;
    chk("rst_valid", lookup_valid_o, 0);
    chk("rst_ready", req_ready_o, 0);
    chk("rst_fvalid", lookup_flush_valid_o, 0);
    chk("rst_busy", flush_busy_o, 0);
    chk("rst_id", lookup_id_o, 0);
    tick(); tick();
    rst_ni        = 1'b1;
    req_addr_i[0] = 32'h1000_0000;
    req_id_i[0]   = 3'h1;
    req_addr_i[1] = 32'h8000_0040;
    req_id_i[1]   = 3'h5;

    // alternating round robin, done one cycle after each handshake
    req_valid_i = 2'b11; lookup_ready_i = 1'b1; #2;
    chk("rr0_valid", lookup_valid_o, 1);
    chk("rr0_id", lookup_id_o, 4'h1);
    chk("rr0_addr", lookup_addr_o, 32'h1000_0000);
    chk("rr0_ready", req_ready_o, 2'b01);
    tick();
    lookup_done_i = 1'b1; #2;
    chk("rr1_id", lookup_id_o, 4'hD);
    chk("rr1_addr", lookup_addr_o, 32'h8000_0040);
    chk("rr1_ready", req_ready_o, 2'b10);
    tick(); #2;
    chk("rr2_id", lookup_id_o, 4'h1);
    chk("rr2_ready", req_ready_o, 2'b01);
    tick(); #2;
    chk("rr3_id", lookup_id_o, 4'hD);
    chk("rr3_ready", req_ready_o, 2'b10);
    tick();
    req_valid_i = 2'b00; #2;
    chk("rr_idle_valid", lookup_valid_o, 0);
    tick();
    lookup_done_i = 1'b0;

    // locked stall on port 1, port 0 joins during the stall
    req_valid_i = 2'b10; lookup_ready_i = 1'b0; #2;
    chk("lk0_valid", lookup_valid_o, 1);
    chk("lk0_addr", lookup_addr_o, 32'h8000_0040);
    chk("lk0_ready", req_ready_o, 2'b00);
    tick();
    req_valid_i = 2'b11; #2;
    chk("lk1_addr", lookup_addr_o, 32'h8000_0040);
    chk("lk1_id", lookup_id_o, 4'hD);
    tick(); #2;
    chk("lk2_addr", lookup_addr_o, 32'h8000_0040);
    tick();
    lookup_ready_i = 1'b1; #2;
    chk("lk3_ready", req_ready_o, 2'b10);
    chk("lk3_id", lookup_id_o, 4'hD);
    tick(); #2;
    chk("lk4_ready", req_ready_o, 2'b01);
    chk("lk4_addr", lookup_addr_o, 32'h1000_0000);
    tick();

    // outstanding limit of 2 reached, one done lets exactly one more issue
    #2;
    chk("full0_valid", lookup_valid_o, 0);
    chk("full0_ready", req_ready_o, 2'b00);
    tick(); #2;
    chk("full1_valid", lookup_valid_o, 0);
    tick();
    lookup_done_i = 1'b1; #2;
    chk("full2_valid", lookup_valid_o, 0);
    tick();
    lookup_done_i = 1'b0; #2;
    chk("refill_valid", lookup_valid_o, 1);
    chk("refill_ready", req_ready_o, 2'b10);
    tick(); #2;
    chk("full3_valid", lookup_valid_o, 0);

    // flush with 2 lookups outstanding
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0; #2;
    chk("fl_busy", flush_busy_o, 1);
    chk("fl_nogrant0", lookup_valid_o, 0);
    tick();
    lookup_done_i = 1'b1; #2;
    chk("fl_drain_valid", lookup_valid_o, 0);
    chk("fl_drain_fv0", lookup_flush_valid_o, 0);
    tick(); #2;
    chk("fl_drain_fv1", lookup_flush_valid_o, 0);
    tick();
    lookup_done_i = 1'b0;
    tick(); #2;
    for (int c = 0; c < 4; c++) begin
      chk("fl_hold_fv", lookup_flush_valid_o, 1);
      chk("fl_hold_nogrant", lookup_valid_o, 0);
      tick();
    end
    lookup_flush_ready_i = 1'b1; #2;
    chk("fl_last_fv", lookup_flush_valid_o, 1);
    tick();
    lookup_flush_ready_i = 1'b0; #2;
    chk("fl_done_fv", lookup_flush_valid_o, 0);
    chk("fl_done_busy", flush_busy_o, 0);
    chk("fl_resume_valid", lookup_valid_o, 1);
    chk("fl_resume_ready", req_ready_o, 2'b01);
    tick();
    req_valid_i = 2'b00; lookup_done_i = 1'b1;
    tick();
    lookup_done_i = 1'b0;

    // flush during a locked stall, then a second flush queued from FLUSH
    req_valid_i = 2'b01; lookup_ready_i = 1'b0; #2;
    chk("lf_valid", lookup_valid_o, 1);
    chk("lf_id", lookup_id_o, 4'h1);
    tick();
    flush_i = 1'b1; #2;
    chk("lf_locked_valid", lookup_valid_o, 1);
    tick();
    flush_i = 1'b0; lookup_ready_i = 1'b1; #2;
    chk("lf_pend_valid", lookup_valid_o, 1);
    chk("lf_pend_busy", flush_busy_o, 1);
    chk("lf_pend_ready", req_ready_o, 2'b01);
    tick();
    req_valid_i = 2'b00; lookup_ready_i = 1'b0; lookup_done_i = 1'b1; #2;
    chk("lf_nogrant", lookup_valid_o, 0);
    tick();
    lookup_done_i = 1'b0; #2;
    chk("lf_drain_busy", flush_busy_o, 1);
    chk("lf_drain_fv", lookup_flush_valid_o, 0);
    tick(); #2;
    chk("lf_flush1_fv", lookup_flush_valid_o, 1);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0; lookup_flush_ready_i = 1'b1; #2;
    chk("lf_flush1b_fv", lookup_flush_valid_o, 1);
    tick();
    lookup_flush_ready_i = 1'b0; #2;
    chk("lf_between_fv", lookup_flush_valid_o, 0);
    chk("lf_between_busy", flush_busy_o, 1);
    tick(); tick(); #2;
    chk("lf_flush2_fv", lookup_flush_valid_o, 1);
    lookup_flush_ready_i = 1'b1;
    tick();
    lookup_flush_ready_i = 1'b0; #2;
    chk("lf_end_fv", lookup_flush_valid_o, 0);
    chk("lf_end_busy", flush_busy_o, 0);
    tick(); tick(); #2;
    chk("lf_no_third", lookup_flush_valid_o, 0);

    // reset asserted during FLUSH
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    tick(); tick(); #2;
    chk("rf_fv", lookup_flush_valid_o, 1);
    rst_ni = 1'b0; #1;
    chk("rf_rst_fv", lookup_flush_valid_o, 0);
    chk("rf_rst_busy", flush_busy_o, 0);
    tick();
    #1 rst_ni = 1'b1;
    req_valid_i = 2'b11; lookup_ready_i = 1'b1; #1;
    chk("rf_grant_ready", req_ready_o, 2'b01);
    chk("rf_grant_id", lookup_id_o, 4'h1);
    chk("rf_grant_addr", lookup_addr_o, 32'h1000_0000);
    tick();
    req_valid_i = 2'b00; lookup_ready_i = 1'b0; lookup_done_i = 1'b1;
    tick();
    lookup_done_i = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/snitch_icache_lookup_sched.md
Name: snitch_icache_lookup_sched

Overview:
- Scheduler in front of the icache lookup stage. Shares its single request port between NR_PORTS fetch requesters (e.g. L0 refill and prefetcher) using round-robin arbitration with grant locking.
- Tags each issued lookup with the requester index so responses can be routed back.
- Sequences flushes: stops issuing, drains in-flight lookups, then runs the lookup flush handshake.

Parameters:
NR_PORTS, 2, number of requesters (>=2).
FETCH_AW, 32, fetch address width.
ID_WIDTH, 3, per-requester transaction ID width.
MAX_OUTST, 2, maximum lookups accepted but not yet completed (>=1).
IDX_W, derived = $clog2(NR_PORTS), requester index width.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_addr_i  in  NR_PORTS x FETCH_AW  per-requester fetch address
req_id_i  in  NR_PORTS x ID_WIDTH  per-requester ID
req_valid_i  in  NR_PORTS  request valid
req_ready_o  out  NR_PORTS  request accepted
lookup_addr_o  out  FETCH_AW  to lookup stage address
lookup_id_o  out  ID_WIDTH+IDX_W  {grant index, req ID}
lookup_valid_o  out  1  lookup request valid
lookup_ready_i  in  1  lookup stage accepts
lookup_done_i  in  1  one lookup result consumed (lookup out valid && ready)
lookup_flush_valid_o  out  1  flush request to lookup stage
lookup_flush_ready_i  in  1  lookup stage flush complete
flush_i  in  1  flush request pulse
flush_busy_o  out  1  flush pending or in progress

Behaviour:
- Reset values: all outputs 0. State IDLE; rr_q=0; lock_q=0; outst_q=0; flush_pend_q=0.
- FSM states:
  - IDLE: issue allowed when outst_q<MAX_OUTST. Enter DRAIN when flush_pend_q=1 and lock_q=0.
  - DRAIN: no new grants. Enter FLUSH when outst_q=0 and no lookup handshake in this cycle.
  - FLUSH: lookup_flush_valid_o=1 and stays high until lookup_flush_ready_i; then return to IDLE. flush_pend_q clears on entry to FLUSH.
- flush_i in any state sets flush_pend_q.
  - A pulse while in FLUSH queues a second full flush.
  - A pulse while in DRAIN merges into the current flush.
  - flush_i and a grant in the same IDLE cycle: the grant still issues and is counted.
- flush_busy_o = flush_pend_q | (state!=IDLE).
- Arbitration (combinational, zero latency):
  - Unlocked: grant goes to the first valid requester searching from rr_q upward, modulo NR_PORTS.
  - Locked: grant = lock_idx_q.
- Issue outputs:
  - lookup_valid_o = issue_allowed & (locked ? 1 : |req_valid_i).
  - Address and ID are muxed from the granted port; lookup_id_o = {grant, req_id_i[grant]}.
  - req_ready_o[g] = issue_allowed & lookup_ready_i & (g==grant); all other bits are 0.
- Lock:
  - If lookup_valid_o && !lookup_ready_i: lock_q<=1 and lock_idx_q<=grant.
  - Cleared on handshake.
  - While locked, issue_allowed is forced 1 (a raised valid is never retracted), including when flush_pend_q is set.
  - Requesters keep addr/id stable until ready; a requester dropping valid while locked is an assertion error.
- Round-robin pointer: on handshake, rr_q <= (grant+1) mod NR_PORTS, using an explicit compare, not a power-of-two wrap.
- Outstanding counter:
  - +1 on lookup handshake, -1 on lookup_done_i, unchanged when both happen.
  - Width $clog2(MAX_OUTST+1).
  - lookup_done_i at outst_q=0 is an assertion error; the counter holds at 0.
  - At outst_q=MAX_OUTST with no lock, lookup_valid_o=0.
- Reset asserted mid-operation returns everything to the reset values immediately. A pending flush is dropped.

Test Plan:
- Port 0 and port 1 both valid continuously, lookup_ready_i=1, lookup_done_i one cycle later -> grants alternate 0,1,0,1; lookup_id_o MSB toggles; each req_ready_o bit high every other cycle.
- Port 1 valid with addr 0x8000_0040, lookup_ready_i low for 3 cycles while port 0 is also valid -> grant stays on port 1, address stable; handshake in cycle 4, then port 0 is granted.
- MAX_OUTST=2, lookup_done_i held 0 -> exactly 2 handshakes, then lookup_valid_o=0; one done pulse -> 1 more issue.
- flush_i with 2 lookups outstanding -> flush_busy_o=1 next cycle, no grants; lookup_flush_valid_o rises the cycle after the second done; ready after 5 cycles -> IDLE, grants resume.
- flush_i during a locked stall -> the locked request still completes, then DRAIN; flush_i pulsed again in FLUSH -> exactly two flush handshakes.
- rst_ni low during FLUSH -> lookup_flush_valid_o=0 and flush_busy_o=0 immediately; after release, the port 0 request is granted first.
